// File: rtl/ibuffer_issue_arb_if.sv
// Handshake bundle between the per-warp instruction buffers, the issue
// arbiter and the downstream operand-collect/dispatch stage.
interface ibuffer_issue_arb_if #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 64,
  parameter int WARP_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
  logic [NUM_WARPS-1:0]       in_valid;
  logic [NUM_WARPS*DATAW-1:0] in_data;
  logic [NUM_WARPS-1:0]       in_ready;
  logic [NUM_WARPS-1:0]       warp_stall;
  logic                       out_valid;
  logic [DATAW-1:0]           out_data;
  logic [WARP_BITS-1:0]       out_wid;
  logic                       out_ready;

  // Arbiter side: consumes warp channels, produces the issue stream.
  modport slave (
    input  in_valid, in_data, warp_stall, out_ready,
    output in_ready, out_valid, out_data, out_wid
  );

  // Environment side: instruction buffers upstream, dispatch downstream.
  modport master (
    output in_valid, in_data, warp_stall, out_ready,
    input  in_ready, out_valid, out_data, out_wid
  );
endinterface

// File: rtl/ibuffer_issue_arb.sv
// Round-robin issue arbiter over per-warp instruction buffers with a
// 2-entry elastic output stage and issue/stall/idle performance counters.
module ibuffer_issue_arb #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 64,
  parameter int WARP_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  ibuffer_issue_arb_if.slave  bus,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stalls,
  output logic [31:0]         perf_idle
);

  logic [WARP_BITS-1:0] r_rr_ptr;
  logic [1:0]           r_count;
  logic                 r_wptr;
  logic                 r_rptr;
  logic [DATAW-1:0]     r_mem_data [2];
  logic [WARP_BITS-1:0] r_mem_wid  [2];
  logic [31:0]          r_perf_issued;
  logic [31:0]          r_perf_stalls;
  logic [31:0]          r_perf_idle;

  logic [NUM_WARPS-1:0] w_elig;
  logic                 w_grant_valid;
  logic [WARP_BITS-1:0] w_grant;
  logic [WARP_BITS-1:0] w_rr_next;
  logic [NUM_WARPS-1:0] w_in_ready;
  logic                 w_buf_full;
  logic                 w_out_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [DATAW-1:0]     w_grant_data;

  // Full flag comes straight from the occupancy register, so in_ready never
  // depends combinationally on out_ready.
  assign w_buf_full  = r_count[1];
  assign w_out_valid = (r_count != 2'd0);
  assign w_elig      = bus.in_valid & ~bus.warp_stall;
  assign w_push      = w_grant_valid && !w_buf_full && !reset;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_rr_next   = (w_grant == WARP_BITS'(NUM_WARPS - 1)) ? '0
                                                              : w_grant + WARP_BITS'(1);

  // Round-robin scan starting at rr_ptr; first eligible warp wins.
  always_comb begin
    int idx;
    idx           = 0;
    w_grant_valid = 1'b0;
    w_grant       = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_WARPS;
      if (!w_grant_valid && w_elig[idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = WARP_BITS'(idx);
      end
    end
  end

  // One-hot pop toward the granted warp's buffer, plus its record.
  always_comb begin
    w_in_ready   = '0;
    w_grant_data = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_grant == WARP_BITS'(i)) begin
        w_in_ready[i] = w_push;
        w_grant_data  = bus.in_data[i*DATAW +: DATAW];
      end
    end
  end

  // Control state: round-robin pointer and FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_count  <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= w_rr_next;
        r_wptr   <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record storage; contents only matter when the occupancy says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_grant_data;
      r_mem_wid[r_wptr]  <= w_grant;
    end
  end

  // Performance counters, free-running and wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stalls <= '0;
      r_perf_idle   <= '0;
    end else begin
      if (w_pop) begin
        r_perf_issued <= r_perf_issued + 32'd1;
      end
      if (w_out_valid && !bus.out_ready) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
      if ((w_elig == '0) && !w_out_valid) begin
        r_perf_idle <= r_perf_idle + 32'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem_data[r_rptr];
  assign bus.out_wid   = r_mem_wid[r_rptr];
  assign perf_issued   = r_perf_issued;
  assign perf_stalls   = r_perf_stalls;
  assign perf_idle     = r_perf_idle;

endmodule

// File: tb/tb_ibuffer_issue_arb.sv
// Directed bench for ibuffer_issue_arb: stimulus pushes hand-computed issue
// records into a scoreboard queue, a monitor pops and compares them.
module tb_ibuffer_issue_arb;
  localparam int NW = 4;
  localparam int DW = 64;
  localparam int WB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perf_issued;
  logic [31:0] perf_stalls;
  logic [31:0] perf_idle;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WB+DW-1:0] exp_q [$];
  int seq [NW] = '{default: 0};
  int nxt [NW] = '{default: 0};
  logic [WB+DW-1:0] hold_exp;

  ibuffer_issue_arb_if #(.NUM_WARPS(NW), .DATAW(DW), .WARP_BITS(WB)) bus ();

  ibuffer_issue_arb #(.NUM_WARPS(NW), .DATAW(DW), .WARP_BITS(WB)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls),
    .perf_idle   (perf_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkdata(input int w, input int s);
    return {16'hC0DE, 16'(w), 32'(s) ^ 32'h5A5A_0000};
  endfunction

  // Upstream buffers: each warp presents a numbered record, advancing on pop.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      bus.in_data[i*DW +: DW] = mkdata(i, seq[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (bus.in_valid[i] === 1'b1 && bus.in_ready[i] === 1'b1) seq[i] <= seq[i] + 1;
    end
  end

  task automatic chk(input string nm, input logic [WB+DW-1:0] act, input logic [WB+DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_exp(input int w);
    exp_q.push_back({WB'(w), mkdata(w, nxt[w])});
    nxt[w]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check the pop vector, record expected transfers, advance.
  task automatic step(input logic [NW-1:0] exp_rdy, input string nm);
    @(negedge clk);
    chk(nm, bus.in_ready, exp_rdy);
    for (int w = 0; w < NW; w++) if (exp_rdy[w]) push_exp(w);
    tick();
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {bus.out_wid, bus.out_data}, '0);
      end else begin
        chk("out_record", {bus.out_wid, bus.out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.in_valid   = '0;
    bus.warp_stall = '0;
    bus.out_ready  = 1'b1;
    tick();
    tick();

    // Reset state, and no pop while reset is held even with warps valid.
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_rr_ptr", dut.r_rr_ptr, 2'd0);
    chk("rst_perf_issued", perf_issued, 32'd0);
    chk("rst_perf_idle", perf_idle, 32'd0);
    bus.in_valid = 4'b1111;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 4'b0000);
    tick();

    // All warps valid, downstream always ready: 0,1,2,3,0,1,2,3.
    reset = 1'b0;
    @(negedge clk);
    chk("lat_out_valid0", bus.out_valid, 1'b0);
    chk("rr_grant0", bus.in_ready, 4'b0001);
    push_exp(0);
    tick();
    for (int n = 1; n < 8; n++) begin
      step(4'b0001 << (n % 4), "rr_grant");
    end
    bus.in_valid = '0;
    tick();
    chk("issued_8", perf_issued, 32'd8);
    chk("rr_after_8", dut.r_rr_ptr, 2'd0);
    chk("drained_1", bus.out_valid, 1'b0);

    // Move rr_ptr to 2, then only warps 0/1 valid: wrap to 0, then 1.
    bus.in_valid = 4'b0010;
    step(4'b0010, "set_rr2");
    chk("rr_is_2", dut.r_rr_ptr, 2'd2);
    bus.in_valid = 4'b0011;
    step(4'b0001, "wrap_grant0");
    step(4'b0010, "wrap_grant1");
    bus.in_valid = '0;
    chk("rr_end_2", dut.r_rr_ptr, 2'd2);
    tick();

    // Warps 0 and 2 stalled: only 3 and 1 alternate.
    bus.in_valid   = 4'b1111;
    bus.warp_stall = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      step((n % 2 == 0) ? 4'b1000 : 4'b0010, "stall_mask");
    end
    bus.in_valid   = '0;
    bus.warp_stall = '0;
    tick();
    chk("rr_after_stall", dut.r_rr_ptr, 2'd2);

    // Backpressure: two records absorbed, output held stable, then drained.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0001;
    hold_exp = {WB'(0), mkdata(0, nxt[0])};
    for (int c = 0; c < 5; c++) begin
      if (c == 3) bus.warp_stall = 4'b0001;
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, (c < 2) ? 4'b0001 : 4'b0000);
      if (c < 2) push_exp(0);
      if (c >= 1) chk("bp_hold", {bus.out_wid, bus.out_data}, hold_exp);
      tick();
    end
    chk("bp_stalls_4", perf_stalls, 32'd4);
    bus.out_ready  = 1'b1;
    bus.in_valid   = '0;
    bus.warp_stall = '0;
    tick();
    tick();
    chk("bp_drained", bus.out_valid, 1'b0);
    chk("bp_issued", perf_issued, 32'd19);

    // Reset while the buffer holds two records.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0001;
    step(4'b0001, "fill_a");
    step(4'b0001, "fill_b");
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 4'b0000);
    exp_q.delete();
    tick();
    reset          = 1'b0;
    bus.in_valid   = '0;
    bus.out_ready  = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_rr", dut.r_rr_ptr, 2'd0);
    chk("midrst_issued", perf_issued, 32'd0);
    chk("midrst_stalls", perf_stalls, 32'd0);
    chk("midrst_idle", perf_idle, 32'd0);

    // Ten cycles with nothing eligible and an empty buffer.
    for (int n = 0; n < 10; n++) begin
      if (n == 5) begin
        bus.in_valid   = 4'b1111;
        bus.warp_stall = 4'b1111;
      end
      step(4'b0000, "idle_no_ready");
    end
    chk("idle_10", perf_idle, 32'd10);
    chk("idle_rr", dut.r_rr_ptr, 2'd0);
    chk("idle_issued", perf_issued, 32'd0);
    bus.in_valid   = '0;
    bus.warp_stall = '0;
    tick();
    chk("queue_empty", 66'(exp_q.size()), 66'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ibuffer_issue_arb.md
Name: ibuffer_issue_arb

Overview:
- Reader side of the per-warp instruction buffer interface.
- Consumes `NUM_WARPS` independent valid/ready instruction channels (one per warp instruction buffer) and merges them into a single issue stream.
- Selection is round-robin; any warp blocked by the scoreboard/barrier stall mask is skipped.
- Sits between the instruction buffers and the operand-collect/dispatch stage. It adds a 2-entry elastic output stage and performance counters.

Parameters:
- NUM_WARPS, 4, number of warp input channels (≥1)
- DATAW, 64, width of one buffered instruction record
- WARP_BITS, max(1, clog2(NUM_WARPS)), width of the warp-id output

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- in_valid  input  NUM_WARPS  per-warp instruction available
- in_data  input  NUM_WARPS*DATAW  per-warp record; warp i occupies bits [i*DATAW +: DATAW]
- in_ready  output  NUM_WARPS  per-warp pop; a transfer occurs when in_valid[i] && in_ready[i]
- warp_stall  input  NUM_WARPS  warp i is ineligible this cycle when set
- out_valid  output  1  issue record available
- out_data  output  DATAW  issued record
- out_wid  output  WARP_BITS  warp id of out_data
- out_ready  input  1  downstream accepts
- perf_issued  output  32  count of out handshakes
- perf_stalls  output  32  cycles with out_valid && !out_ready
- perf_idle  output  32  cycles with no eligible warp and out_valid==0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - out_valid=0, in_ready=0, both buffer entries empty.
  - rr_ptr=0 and all perf counters=0.
  - out_data/out_wid are don't-care while out_valid=0.
- Eligibility: eligible[i] = in_valid[i] && !warp_stall[i], evaluated in the same cycle (combinational).
- Grant:
  - The first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_WARPS.
  - At most one grant per cycle; no grant when no warp is eligible.
- in_ready[i] = grant_valid && (grant==i) && !buf_full.
  - At most one bit is set.
  - It never asserts for an ineligible warp.
- Pointer update: on an input transfer from warp g, rr_ptr <= (g+1) mod NUM_WARPS. Otherwise rr_ptr holds.
- Output buffer:
  - 2-entry FIFO holding {wid, data}.
  - buf_full is a registered signal, so in_ready has no combinational path from out_ready.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged when both happen.
  - Records are emitted in acceptance order.
- Throughput and latency:
  - Latency from input transfer to out_valid is 1 cycle.
  - Sustained rate is 1 record/cycle while out_ready=1.
  - When out_ready drops, the buffer absorbs at most 2 records, then in_ready deasserts.
- Data integrity: out_data/out_wid stay stable while out_valid && !out_ready.
- Counters:
  - 32-bit, wrap on overflow.
  - Each counter increments at most once per cycle.
  - perf_idle uses the registered out_valid.
- Boundary conditions:
  - NUM_WARPS=1: the grant is always 0 and rr_ptr stays 0.
  - warp_stall rising in the same cycle as in_valid means no transfer from that warp.
  - warp_stall changing while a record is already in the buffer has no effect on that record.
  - An input with in_valid=0 is never granted, even when rr_ptr points at it.
- Reset mid-operation: buffered records are discarded. The upstream buffers keep their entries because no in_ready was given for them.

Test Plan:
- Reset, then assert in_valid=4'b1111 with out_ready=1 held high:
  - grants follow 0,1,2,3,0…
  - out_wid sequence is 0,1,2,3 starting 1 cycle after the first transfer.
  - perf_issued=8 after 8 handshakes.
- rr_ptr=2 with only in_valid=4'b0011:
  - warp 0 is granted first, then warp 1.
  - rr_ptr ends at 2.
- in_valid=4'b1111, warp_stall=4'b0101:
  - only warps 1 and 3 transfer, alternating.
  - in_ready[0] and in_ready[2] stay 0 throughout.
- Downstream backpressure:
  - out_ready=0 for 5 cycles with warp 0 continuously valid: exactly 2 records are accepted, in_ready[0]=0 afterwards, perf_stalls=4.
  - out_data stays stable over that window.
  - Releasing out_ready drains both records in order.
- Reset asserted while the buffer holds 2 records:
  - next cycle out_valid=0, rr_ptr=0 and all counters 0.
  - no in_ready is asserted during the reset cycle.
- No warp eligible for 10 cycles with the buffer empty:
  - perf_idle=10.
  - no in_ready asserted and rr_ptr unchanged.
